// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator: h/v counters plus a registered sync/enable/marker stage.
// Optional frame counter output is enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int CNT_W      = 10,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             ce,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    initial begin
        if (H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W)
            $error("vga_timing_gen: H_TOTAL=%0d or V_TOTAL=%0d exceeds 2**CNT_W=%0d",
                   H_TOTAL, V_TOTAL, 2 ** CNT_W);
        if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1)
            $error("vga_timing_gen: sync widths and active sizes must be >= 1");
    end

    logic [CNT_W-1:0] h_int;
    logic [CNT_W-1:0] v_int;
    logic             h_last;
    logic             v_last;
    logic             hs_act;
    logic             vs_act;
    logic             de_d;
    logic             line_end_d;
    logic             frame_start_d;

    // Decode is done in int so a sync end equal to 2**CNT_W cannot truncate to zero.
    always_comb begin
        h_last        = 1'b0;
        v_last        = 1'b0;
        hs_act        = 1'b0;
        vs_act        = 1'b0;
        de_d          = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;
        h_last        = int'(h_int) == H_TOTAL - 1;
        v_last        = int'(v_int) == V_TOTAL - 1;
        hs_act        = int'(h_int) >= H_SYNC_START && int'(h_int) < H_SYNC_END;
        vs_act        = int'(v_int) >= V_SYNC_START && int'(v_int) < V_SYNC_END;
        de_d          = int'(h_int) < H_ACTIVE && int'(v_int) < V_ACTIVE;
        line_end_d    = h_last;
        frame_start_d = h_int == '0 && v_int == '0;
    end

    // ce is a pure advance qualifier: with ce low every register, markers included, holds.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            h_int       <= '0;
            v_int       <= '0;
            h_count     <= '0;
            v_count     <= '0;
            hsync       <= !H_SYNC_POL;
            vsync       <= !V_SYNC_POL;
            de          <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            h_count     <= h_int;
            v_count     <= v_int;
            hsync       <= hs_act ? H_SYNC_POL : !H_SYNC_POL;
            vsync       <= vs_act ? V_SYNC_POL : !V_SYNC_POL;
            de          <= de_d;
            line_end    <= line_end_d;
            frame_start <= frame_start_d;
            if (h_last) begin
                h_int <= '0;
                v_int <= v_last ? '0 : v_int + 1'b1;
            end else begin
                h_int <= h_int + 1'b1;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_int;

    // frame_int counts completed frames; the output copy lines up with pixel (0,0) of the next frame.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            frame_int   <= '0;
            frame_count <= '0;
        end else if (ce) begin
            frame_count <= frame_int;
            if (h_last && v_last)
                frame_int <= frame_int + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: driver pushes expected pixels from a linear pixel-index model,
// a monitor pops and compares on every ce edge and checks that outputs hold otherwise.
module tb_vga_timing_gen;

  localparam int CW = 5;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 3, VB = 4;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs;
    logic          vs;
    logic          de;
    logic          le;
    logic          fs;
    logic [15:0]   fc;
  } exp_t;

  logic          clk_25MHz = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_end;
  logic          frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   p = 0;

  vga_timing_gen #(
    .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(HP), .V_SYNC_POL(VP)
  ) dut (
    .clk_25MHz(clk_25MHz),
    .reset(reset),
    .ce(ce),
    .h_count(h_count),
    .v_count(v_count),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .line_end(line_end),
    .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  // clock / reset
  always #5 clk_25MHz = ~clk_25MHz;

  // reference model: pixel n after reset is raster position n mod frame, frame number n / frame
  function automatic exp_t model(int n);
    exp_t e;
    int h, v, f;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FR;
    e.h  = CW'(h);
    e.v  = CW'(v);
    e.hs = (h >= HA + HF && h < HA + HF + HS) ? HP : !HP;
    e.vs = (v >= VA + VF && v < VA + VF + VS) ? VP : !VP;
    e.de = (h < HA) && (v < VA);
    e.le = (h == HT - 1);
    e.fs = (h == 0) && (v == 0);
`ifdef VGA_FRAME_COUNT_EN
    e.fc = 16'(f);
`else
    e.fc = 16'(0);
`endif
    return e;
  endfunction

  function automatic exp_t rst_val();
    exp_t e;
    e = '0;
    e.hs = !HP;
    e.vs = !VP;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.h  = h_count;
    s.v  = v_count;
    s.hs = hsync;
    s.vs = vsync;
    s.de = de;
    s.le = line_end;
    s.fs = frame_start;
`ifdef VGA_FRAME_COUNT_EN
    s.fc = frame_count;
`else
    s.fc = '0;
`endif
    return s;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b le=%b fs=%b fc=%0d; need h=%0d v=%0d hs=%b vs=%b de=%b le=%b fs=%b fc=%0d",
               name, $time, act.h, act.v, act.hs, act.vs, act.de, act.le, act.fs, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.le, exp.fs, exp.fc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d need %0d", name, $time, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, expected pixel pushed per ce edge
  task automatic drive(input bit c);
    @(negedge clk_25MHz);
    ce = c;
    if (c) begin
      exp_q.push_back(model(p));
      p++;
    end
  endtask

  task automatic release_rst();
    @(negedge clk_25MHz);
    reset = 1'b0;
    ce = 1'b1;
    p = 0;
    exp_q.push_back(model(p));
    p++;
  endtask

  task automatic do_reset(input int cycles, input int offset);
    @(negedge clk_25MHz);
    ce = 1'($urandom_range(0, 1));
    #(offset);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async", sample(), rst_val());
    repeat (cycles) begin
      @(negedge clk_25MHz);
      ce = 1'($urandom_range(0, 1));
    end
    check("rst_hold", sample(), rst_val());
    release_rst();
  endtask

  // scoreboard monitor
  initial begin
    exp_t a, e, last;
    bit ce_s, rst_s, gap_ok;
    int gap;
    last = rst_val();
    gap_ok = 1'b0;
    gap = 0;
    forever begin
      @(posedge clk_25MHz);
      ce_s = ce;
      rst_s = reset;
      #2;
      a = sample();
      if (rst_s) begin
        last = rst_val();
        gap_ok = 1'b0;
      end else if (ce_s) begin
        if (exp_q.size() == 0) begin
          check_int("sb_underflow", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("pix", a, e);
          last = e;
        end
        gap++;
        if (a.fs) begin
          if (gap_ok) check_int("frame_len", gap, FR);
          gap = 0;
          gap_ok = 1'b1;
        end
      end else begin
        check("hold", a, last);
      end
    end
  end

  // stimulus
  initial begin
    int n;
    repeat (3) @(negedge clk_25MHz);
    check("rst_init", sample(), rst_val());
    release_rst();
    repeat (FR + FR / 2) drive(1'b1);
    n = 0;
    repeat (3 * FR + 50) begin
      drive(n % 3 == 0);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(20, 400)) drive($urandom_range(0, 3) != 0);
      do_reset($urandom_range(1, 3), $urandom_range(0, 4));
    end
    repeat (3 * HT + 4) drive(1'b1);
    do_reset(2, 2);
    repeat (3 * FR + 10) drive(1'b1);
    @(negedge clk_25MHz);
    ce = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    check_int("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/VESA raster timing generator. It replaces the fixed 800-count horizontal counter with one block that contains both the horizontal and vertical counters. It also produces hsync, vsync, display-enable and line/frame markers for any resolution. It sits between the pixel-clock source and the pixel/colour pipeline.

Parameters:
CNT_W, 10, width of h_count/v_count; must hold H_TOTAL-1 and V_TOTAL-1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk_25MHz  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high
ce  in  1  pixel advance enable; when low, all state holds
h_count  out  CNT_W  horizontal position of current output pixel
v_count  out  CNT_W  vertical position of current output pixel
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
de  out  1  display enable: 1 when h_count<H_ACTIVE and v_count<V_ACTIVE
line_end  out  1  1 when h_count==H_TOTAL-1
frame_start  out  1  1 when h_count==0 and v_count==0

Behaviour:
- Derived values: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default).
- Internal counters h_int and v_int. On each rising edge with ce=1:
  - Output stage <= decode(h_int, v_int).
  - h_int increments. At H_TOTAL-1 it wraps to 0 and v_int advances.
  - v_int wraps from V_TOTAL-1 to 0 only when h_int also wraps.
- All outputs are registered in the same stage and are mutually aligned. Latency from internal count to output is 1 ce-cycle.
- Sync decode:
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - vsync changes on the same pixel as h_count returns to 0; there is no half-line offset.
- ce=0: internal counters and every output hold their values. Pulses (line_end, frame_start) stay asserted for as long as the marked pixel is held; consumers qualify them with ce.
- Reset (asserted at any time, including mid-line or mid-frame):
  - h_int, v_int, h_count, v_count = 0.
  - hsync = ~H_SYNC_POL and vsync = ~V_SYNC_POL (inactive levels).
  - de, line_end, frame_start = 0.
- First ce=1 edge after reset release outputs pixel (0,0): de=1, frame_start=1.
- Counter widths: comparisons are unsigned at CNT_W. A parameter set whose H_TOTAL or V_TOTAL exceeds 2^CNT_W is illegal and must be flagged by a simulation-time check ($error in an initial block).
- Each of H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be >=1. Porches may be 0.

Optional Feature:
VGA_FRAME_COUNT_EN
- Defined: adds output frame_count (16 bits, reset 0). It is registered in the output stage and increments on each frame wrap. It equals the number of completed frames while frame_start=1, and wraps at 65535->0.
- Undefined: no frame_count port and no frame-counter logic; everything else is identical.

Test Plan:
- Default params, reset released, ce=1 constantly: first ce edge gives h_count=0, v_count=0, de=1, frame_start=1, hsync=1, vsync=1.
- Default params, horizontal sync: hsync=0 exactly for h_count 656..751; line_end=1 only at h_count=799, followed by h_count=0 and v_count+1.
- Default params, vertical sync and frame length:
  - vsync=0 exactly for v_count 490..491.
  - de=0 for all pixels with h_count>=640 or v_count>=480.
  - Successive frame_start pulses are 420000 ce-cycles apart.
- ce toggled with a 1-in-3 pattern: counts advance only on ce edges; all outputs frozen otherwise; frame length 420000 ce-qualified cycles.
- Small params (H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=1), reset asserted at h=5, v=3 then released:
  - During reset, outputs go to reset values immediately (asynchronous) and hsync=0.
  - Next ce edge outputs (0,0).
  - hsync=1 only at h_count 5..6.
- With VGA_FRAME_COUNT_EN: run 3 frames -> frame_count reads 0, 1, 2 at successive frame_start pulses.
